timer_prog_periodic: RTL

- Parametrised, programmable interval timer; successor to the fixed 1 s timeout block.
- A built-in prescaler divides clk into ticks of CLK_DIV cycles. A tick counter measures a runtime-loaded number of ticks.
- Supports one-shot and periodic modes, pause/resume, abort and restart.
- Used by the LCD controller for power-up waits, command settle delays and cursor-blink periods.

---
 rtl/timer_prog_periodic.sv | 107 ++++++++++
 1 files changed

// File: rtl/timer_prog_periodic.sv
// Programmable interval timer: a prescaler divides clk into ticks and a tick
// counter measures a run-time loaded period, in one-shot or periodic mode.
module timer_prog_periodic #(
   parameter int unsigned CLK_DIV = 50000,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned PRE_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode,
   input  logic [CNT_W-1:0] load_val,
   output logic             TimeOut,
   output logic             busy,
   output logic [CNT_W-1:0] elapsed
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } stateT;

   stateT            state, stateNext;
   logic [PRE_W-1:0] prescaler, prescalerNext;
   logic [CNT_W-1:0] period, periodNext;
   logic             modeLatched, modeNext;
   logic [CNT_W-1:0] elapsedNext;
   logic             timeOutNext;
   logic             busyNext;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         prescaler   <= '0;
         period      <= '0;
         modeLatched <= 1'b0;
         elapsed     <= '0;
         TimeOut     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         prescaler   <= prescalerNext;
         period      <= periodNext;
         modeLatched <= modeNext;
         elapsed     <= elapsedNext;
         TimeOut     <= timeOutNext;
         busy        <= busyNext;
      end
   end

   // Next-state and next-output logic; priority stop > start > pause > expiry
   always_comb begin
      stateNext     = state;
      prescalerNext = prescaler;
      periodNext    = period;
      modeNext      = modeLatched;
      elapsedNext   = elapsed;
      timeOutNext   = 1'b0;

      if (stop) begin
         stateNext     = IDLE;
         prescalerNext = '0;
         elapsedNext   = '0;
      end else if (start) begin
         prescalerNext = '0;
         elapsedNext   = '0;
         // A zero load is ignored in IDLE and behaves as an abort in RUN
         if (load_val != '0) begin
            stateNext  = RUN;
            periodNext = load_val;
            modeNext   = mode;
         end else begin
            stateNext  = IDLE;
         end
      end else if (state == RUN && !pause) begin
         if (prescaler == PRE_LAST) begin
            prescalerNext = '0;
            if (elapsed == CNT_W'(period - 1'b1)) begin
               timeOutNext = 1'b1;
               elapsedNext = '0;
               if (!modeLatched) begin
                  stateNext = IDLE;
               end
            end else begin
               elapsedNext = CNT_W'(elapsed + 1'b1);
            end
         end else begin
            prescalerNext = PRE_W'(prescaler + 1'b1);
         end
      end

      busyNext = (stateNext == RUN);
   end

endmodule
